// File: rtl/vga_bitmap_display_if.sv
// Bitmap row write port of the VGA bitmap display.
interface vga_bitmap_display_if #(
  parameter int AW    = 6,
  parameter int BMP_W = 50
);
  logic             wrEn;
  logic [AW-1:0]    wrAddr;
  logic [BMP_W-1:0] wrData;

  modport master (output wrEn, wrAddr, wrData);
  modport slave  (input  wrEn, wrAddr, wrData);
endinterface

// File: rtl/vga_bitmap_display.sv
// VGA raster generator rendering a writable monochrome bitmap, each bit
// magnified to a 2^SCALE_LOG2 pixel square. All outputs are registered one
// cycle behind the raster counters.
module vga_bitmap_display #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int COLOR_W    = 4,
  parameter int BMP_W      = 50,
  parameter int BMP_ROWS   = 36,
  parameter int SCALE_LOG2 = 4
) (
  input  logic                   pixelClock,
  input  logic                   resetN,
  vga_bitmap_display_if.slave    wr,
  input  logic [3*COLOR_W-1:0]   fgColor,
  input  logic [3*COLOR_W-1:0]   bgColor,
  output logic [COLOR_W-1:0]     Red,
  output logic [COLOR_W-1:0]     Green,
  output logic [COLOR_W-1:0]     Blue,
  output logic                   hSync,
  output logic                   vSync,
  output logic                   active,
  output logic                   frameStart
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = (BMP_ROWS > 1) ? $clog2(BMP_ROWS) : 1;
  // Row-index width with one spare bit so BMP_ROWS itself is representable.
  localparam int IW      = ((VW > AW) ? VW : AW) + 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] SC_MASK = HW'((1 << SCALE_LOG2) - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [IW-1:0] ROW_LIM = IW'(BMP_ROWS);

  logic [HW-1:0]        h_count;
  logic [VW-1:0]        v_count;
  logic [BMP_W-1:0]     bmp [BMP_ROWS];
  logic [BMP_W-1:0]     shreg;
  logic [3*COLOR_W-1:0] fg_reg;
  logic [3*COLOR_W-1:0] bg_reg;
  logic [3*COLOR_W-1:0] pix_q;

  logic          h_last;
  logic          v_last;
  logic [VW-1:0] v_next;
  logic [IW-1:0] load_row;
  logic          load_ok;
  logic [IW-1:0] wr_row;
  logic          wr_ok;
  logic          visible;
  logic          shift_en;

  assign h_last   = (h_count == H_LAST);
  assign v_last   = (v_count == V_LAST);
  assign v_next   = v_last ? '0 : v_count + VW'(1);
  assign load_row = IW'(v_next >> SCALE_LOG2);
  assign load_ok  = (v_next < V_VIS) && (load_row < ROW_LIM);
  assign wr_row   = IW'(wr.wrAddr);
  assign wr_ok    = wr.wrEn && (wr_row < ROW_LIM);
  assign visible  = (h_count < H_VIS) && (v_count < V_VIS);
  assign shift_en = (h_count < H_VIS) && ((h_count & SC_MASK) == SC_MASK);

  assign {Red, Green, Blue} = pix_q;

  // Raster position: pixel counter wraps each line, line counter each frame.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_last) begin
      h_count <= '0;
      v_count <= v_next;
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  // Bitmap store; out-of-range row addresses are dropped.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < BMP_ROWS; i++) bmp[i] <= '0;
    end else if (wr_ok) begin
      bmp[wr.wrAddr] <= wr.wrData;
    end
  end

  // Line buffer: loaded with the next line's row at end of line (old data on
  // a same-cycle write), then shifted once per magnified bit.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      shreg <= '0;
    end else if (h_last) begin
      shreg <= load_ok ? bmp[load_row[AW-1:0]] : '0;
    end else if (shift_en) begin
      shreg <= shreg << 1;
    end
  end

  // Colours are latched only at the last pixel of a frame.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      fg_reg <= '1;
      bg_reg <= '0;
    end else if (h_last && v_last) begin
      fg_reg <= fgColor;
      bg_reg <= bgColor;
    end
  end

  // Registered pixel, sync, data-enable and frame marker.
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      pix_q      <= '0;
      hSync      <= !HS_POL;
      vSync      <= !VS_POL;
      active     <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      pix_q      <= visible ? (shreg[BMP_W-1] ? fg_reg : bg_reg) : '0;
      hSync      <= ((h_count >= HS_BEG) && (h_count < HS_END)) ? HS_POL : !HS_POL;
      vSync      <= ((v_count >= VS_BEG) && (v_count < VS_END)) ? VS_POL : !VS_POL;
      active     <= visible;
      frameStart <= (h_count == '0) && (v_count == '0);
    end
  end

endmodule

// File: tb/tb_vga_bitmap_display.sv
// Bench for vga_bitmap_display using a shrunken raster so several frames fit
// in a short run. Expected outputs come from a position-based model of the
// displayed image.
module tb_vga_bitmap_display;
  localparam int HA = 40, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 16, VFP = 2, VSW = 3, VBP = 3;
  localparam bit HS_P = 1'b0, VS_P = 1'b1;
  localparam int CW = 4, BW = 8, ROWS = 3, S = 2, AW = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FR = HT * VT;
  localparam logic [15:0] RST_V = {12'h000, !HS_P, !VS_P, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic [3*CW-1:0] fg_color = 12'hFFF;
  logic [3*CW-1:0] bg_color = 12'h000;
  logic [CW-1:0] red, green, blue;
  logic h_sync, v_sync, active, frame_start;

  vga_bitmap_display_if #(.AW(AW), .BMP_W(BW)) wr_bus ();

  vga_bitmap_display #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HS_P), .VS_POL(VS_P), .COLOR_W(CW), .BMP_W(BW),
    .BMP_ROWS(ROWS), .SCALE_LOG2(S)
  ) dut (
    .pixelClock(clk), .resetN(resetN), .wr(wr_bus.slave),
    .fgColor(fg_color), .bgColor(bg_color),
    .Red(red), .Green(green), .Blue(blue),
    .hSync(h_sync), .vSync(v_sync), .active(active), .frameStart(frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;
  int cycles = 0;
  int last_fs = -1;
  logic [BW-1:0] mbmp [ROWS];
  logic [BW-1:0] line_buf;
  logic [11:0] fg_m, bg_m;
  logic [11:0] last_rgb;

  task automatic model_reset();
    for (int i = 0; i < ROWS; i++) mbmp[i] = '0;
    line_buf = '0;
    fg_m = 12'hFFF;
    bg_m = 12'h000;
    n = 0;
    last_fs = -1;
  endtask

  // One pixel clock: predict the output for the current raster position,
  // advance the model, clock the DUT and compare.
  task automatic tick();
    int x, y, ny, col;
    logic vis, hs_e, vs_e;
    logic [11:0] ce;
    logic [15:0] ev, ov;
    x = n % HT;
    y = (n / HT) % VT;
    vis = (x < HA) && (y < VA);
    col = x >> S;
    ce = 12'h000;
    if (vis) begin
      ce = bg_m;
      if (col < BW) begin
        if (line_buf[BW-1-col]) ce = fg_m;
      end
    end
    hs_e = (x >= HA + HFP && x < HA + HFP + HSW) ? HS_P : !HS_P;
    vs_e = (y >= VA + VFP && y < VA + VFP + VSW) ? VS_P : !VS_P;
    ev = {ce, hs_e, vs_e, vis, (x == 0 && y == 0)};
    if (x == HT - 1) begin
      ny = (y == VT - 1) ? 0 : y + 1;
      if (ny < VA && (ny >> S) < ROWS) line_buf = mbmp[ny >> S];
      else line_buf = '0;
      if (y == VT - 1) begin
        fg_m = fg_color;
        bg_m = bg_color;
      end
    end
    if (wr_bus.wrEn && int'(wr_bus.wrAddr) < ROWS) mbmp[wr_bus.wrAddr] = wr_bus.wrData;
    n++;
    @(posedge clk);
    #1;
    cycles++;
    ov = {red, green, blue, h_sync, v_sync, active, frame_start};
    last_rgb = {red, green, blue};
    checks++;
    assert (ov === ev) else begin
      errors++;
      $error("FAIL pixel x=%0d y=%0d observed=%h expected=%h", x, y, ov, ev);
    end
    if (frame_start) begin
      if (last_fs >= 0) begin
        checks++;
        assert (cycles - last_fs === FR) else begin
          errors++;
          $error("FAIL frame_period observed=%0d expected=%0d", cycles - last_fs, FR);
        end
      end
      last_fs = cycles;
    end
  endtask

  task automatic run_to(int x, int y);
    int guard = 0;
    while (((n % HT) != x || ((n / HT) % VT) != y) && guard <= FR) begin
      tick();
      guard++;
    end
  endtask

  task automatic wr_at(int x, int y, logic [AW-1:0] addr, logic [BW-1:0] data);
    run_to(x, y);
    wr_bus.wrEn = 1'b1;
    wr_bus.wrAddr = addr;
    wr_bus.wrData = data;
    tick();
    wr_bus.wrEn = 1'b0;
  endtask

  task automatic check_px(string tag, int x, int y, logic [11:0] exp_rgb);
    run_to(x, y);
    tick();
    checks++;
    assert (last_rgb === exp_rgb) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, last_rgb, exp_rgb);
    end
  endtask

  task automatic check_rst(string tag);
    logic [15:0] ov;
    ov = {red, green, blue, h_sync, v_sync, active, frame_start};
    checks++;
    assert (ov === RST_V) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, ov, RST_V);
    end
  endtask

  task automatic random_run(int len);
    for (int i = 0; i < len; i++) begin
      wr_bus.wrEn = ($urandom_range(7) == 0);
      wr_bus.wrAddr = AW'($urandom_range(3));
      wr_bus.wrData = BW'($urandom);
      if ($urandom_range(299) == 0) fg_color = 12'($urandom);
      if ($urandom_range(299) == 0) bg_color = 12'($urandom);
      tick();
    end
    wr_bus.wrEn = 1'b0;
  endtask

  initial begin
    wr_bus.wrEn = 1'b0;
    wr_bus.wrAddr = '0;
    wr_bus.wrData = '0;
    model_reset();

    repeat (3) begin
      @(posedge clk);
      #1;
      check_rst("reset_hold");
    end
    resetN = 1'b1;

    // Frame 0: load rows, including an out-of-range address.
    wr_at(10, 2, 2'd0, 8'h80);
    wr_at(11, 2, 2'd2, 8'hFF);
    wr_at(12, 2, 2'd3, 8'h55);

    // Frame 1: white on black.
    check_px("row0_px0", 0, 1, 12'hFFF);
    check_px("row0_px3", 3, 1, 12'hFFF);
    check_px("row0_px4", 4, 1, 12'h000);
    check_px("row2_px20", 20, 9, 12'hFFF);
    check_px("row2_px31", 31, 9, 12'hFFF);
    check_px("beyond_bmp_w", 32, 9, 12'h000);
    check_px("row_over_rows", 10, 13, 12'h000);
    run_to(0, 14);
    fg_color = 12'hF00;
    bg_color = 12'h00F;
    check_px("colour_hold_frame", 0, 15, 12'h000);

    // Frame 2: new colours, then a write racing the line load.
    check_px("fg_new_frame", 0, 0, 12'hF00);
    check_px("bg_new_frame", 4, 0, 12'h00F);
    check_px("hblank_zero", 45, 0, 12'h000);
    wr_at(HT - 1, 3, 2'd1, 8'hFF);
    check_px("race_old_data", 0, 4, 12'h00F);
    check_px("race_new_data", 0, 5, 12'hF00);
    check_px("vblank_zero", 20, 20, 12'h000);

    random_run(3 * FR);

    // Reset in the middle of a line.
    run_to(20, 6);
    #2;
    resetN = 1'b0;
    #1;
    check_rst("reset_async");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_rst("reset_mid_hold");
    end
    resetN = 1'b1;
    model_reset();
    random_run(2 * FR + 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
